mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multi-cycle successor to the single-cycle datapath: one instruction executes over 3-5 states.
//  Supported subset: R-type add/sub/and/or/slt, addi, lw, sw, beq, j, jal.
//  Instruction and data memories are external; each is accessed through a req/ack handshake,
//  so wait-state memories are supported. A memory timeout stops the core in a trap state.
//  The core owns the PC, the register file and the ALU.
// PARAMETERS
//  NREGS       32      architectural registers; power of two, 2..32; $0 reads as zero
//  RESET_PC    32'h0   PC value loaded by reset
//  MEM_TIMEOUT 16      max cycles req may wait for ack before trap; >=1
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-low; asserted when 0
//  imem_req     out  1   instruction fetch request, held until ack
//  imem_addr    out  32  fetch address (= PC)
//  imem_rdata   in   32  instruction word, valid when imem_ack=1
//  imem_ack     in   1   fetch complete
//  dmem_req     out  1   data access request, held until ack
//  dmem_we      out  1   1 = store (sw), 0 = load (lw)
//  dmem_addr    out  32  ALU result (base + sext imm)
//  dmem_wdata   out  32  rt value (sw)
//  dmem_rdata   in   32  load data, valid when dmem_ack=1
//  dmem_ack     in   1   data access complete
//  pc           out  32  current PC
//  resultadoALU out  32  registered ALU result of last EXEC
//  instr_done   out  1   1-cycle pulse when an instruction retires
//  trap         out  1   sticky; core halted
//  trap_cause   out  3   0 none, 1 illegal op/funct/reg idx, 2 imem timeout, 3 dmem timeout, 4 misaligned
// BEHAVIOUR
//  Reset (reset=0 at posedge):
//   state=FETCH; pc=RESET_PC; all other outputs 0; timeout counter 0.
//   Register file contents are not cleared.
//  FETCH:
//   imem_req=1. When imem_ack=1, IR<=imem_rdata and go to DECODE.
//   ack in the same cycle as req is legal (0-wait).
//  DECODE:
//   Read rs/rt and sext(imm). Go to TRAP(1) if the opcode/funct is unsupported or
//   any register index >= NREGS.
//  EXEC:
//   ALU op; resultadoALU<=result.
//   beq: if rs==rt, pc<=pc+4+(sext<<2); else pc<=pc+4. Retire.
//   j: pc<={pc+4[31:28],tgt,2'b00}. Retire.
//   lw/sw: if addr[1:0]!=0, go to TRAP(4); else go to MEM.
//   R/addi/jal: go to WB.
//  MEM:
//   dmem_req=1, dmem_we=(sw). On dmem_ack: sw retires; lw goes to WB with data latched.
//  WB:
//   R writes rd, addi writes rt, lw writes rt with load data, jal writes r31 with pc+4.
//   Writes to $0 are dropped. pc<=pc+4, except jal, where pc<=jump target. Retire.
//  Retire:
//   instr_done=1 for exactly one cycle; state returns to FETCH.
//  Latency (0-wait memory), cycles per instruction:
//   beq/j = 3; R/addi/sw/jal = 4; lw = 5.
//  Arithmetic:
//   32-bit modulo; add/sub overflow ignored; slt is signed; PC wraps at 2^32.
//  Timeout:
//   Counter clears when req rises; it increments while req=1 and ack=0.
//   When the count reaches MEM_TIMEOUT, go to TRAP(2 or 3). An ack in that same cycle wins.
//  TRAP:
//   req outputs 0; pc frozen; no register writes; trap=1. Exit only through reset.
//  Reset mid-access:
//   req drops on the next cycle; any late ack while in FETCH-after-reset is treated as a
//   valid ack (memory must abort on req deassert).
//  imem_req/dmem_req are never both 1. Acks arriving outside their request are ignored.
// STRUCTURE
//  Package mc_pkg:
//   opcode/funct localparams; state enum FETCH, DECODE, EXEC, MEM, WB, TRAP;
//   trap_cause codes; ALU op encoding.
//  Sub-module mc_regfile #(NREGS):
//   2 async read ports, 1 sync write port, index 0 hardwired to zero.
//  ALU, decode and FSM stay inline in mc_datapath.
// TESTING
//  addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 with 0-wait memory
//   -> r3=12, resultadoALU=12, instr_done every 4 cycles, pc=0xC.
//  sw r3,8(r0); lw r4,8(r0) with 3-wait dmem
//   -> store of 12 to addr 8; r4=12; lw takes 5+3 cycles.
//  beq r1,r1,-1 at pc=0x10 -> pc back to 0x10 after 3 cycles.
//  jal 0x40 at pc=0x20 -> r31=0x24, pc=0x100.
//  Illegal opcode 6'h3F -> trap=1, cause=1; pc frozen.
//  imem_ack withheld with MEM_TIMEOUT=16 -> trap cause=2 after 16 cycles.
//  reset=0 mid-MEM -> dmem_req=0 next cycle; pc=RESET_PC.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle datapath: opcodes, functs, FSM states,
// trap causes, ALU operations and the decoded instruction class.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    TC_NONE     = 3'd0,
    TC_ILLEGAL  = 3'd1,
    TC_IMEM_TO  = 3'd2,
    TC_DMEM_TO  = 3'd3,
    TC_MISALIGN = 3'd4
  } trap_cause_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Instruction class after decode; K_ILL marks anything outside the subset.
  typedef enum logic [2:0] {
    K_ILL  = 3'd0,
    K_R    = 3'd1,
    K_ADDI = 3'd2,
    K_LW   = 3'd3,
    K_SW   = 3'd4,
    K_BEQ  = 3'd5,
    K_J    = 3'd6,
    K_JAL  = 3'd7
  } kind_t;

  // True when a 5-bit register field names an implemented register.
  function automatic logic reg_ok(input logic [4:0] idx, input int nregs);
    return (int'(idx) < nregs);
  endfunction

  // 32-bit modulo ALU; slt compares as signed.
  function automatic logic [31:0] alu_calc(input alu_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Index 0 always reads zero and ignores writes. Contents are not reset.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] ra1,
  output logic [31:0]   rd1,
  input  logic [AW-1:0] ra2,
  output logic [31:0]   rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd
);

  logic [31:0] regs [NREGS];

  // Write port; writes to index 0 are discarded.
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction.
// Memory handshake: req is raised on entry to FETCH/MEM and held until ack; a
// transfer completes in the cycle where req && ack are both 1 (ack in the first
// req cycle is allowed). Acks seen while req is low are ignored. A request that
// waits MEM_TIMEOUT cycles without ack sends the core to TRAP.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int          NREGS       = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] pc,
  output logic [31:0] resultadoALU,
  output logic        instr_done,
  output logic        trap,
  output logic [2:0]  trap_cause
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  trap_cause_t cause_q, cause_d;
  logic        done_q, done_d;

  logic [31:0] ir_q, a_q, b_q, alu_q, mdr_q;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_f, rt_f, rd_f, shamt;
  logic [25:0] tgt;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign rs_f     = ir_q[25:21];
  assign rt_f     = ir_q[20:16];
  assign rd_f     = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign tgt      = ir_q[25:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  kind_t   kind;
  alu_op_t alu_op;
  logic    legal;

  // Decode the held instruction into a class, ALU op and legality flag.
  always_comb begin
    kind   = K_ILL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (shamt == 5'd0) begin
          case (funct)
            FN_ADD:  begin kind = K_R; alu_op = ALU_ADD; end
            FN_SUB:  begin kind = K_R; alu_op = ALU_SUB; end
            FN_AND:  begin kind = K_R; alu_op = ALU_AND; end
            FN_OR:   begin kind = K_R; alu_op = ALU_OR;  end
            FN_SLT:  begin kind = K_R; alu_op = ALU_SLT; end
            default: kind = K_ILL;
          endcase
        end
      end
      OP_ADDI: kind = K_ADDI;
      OP_LW:   kind = K_LW;
      OP_SW:   kind = K_SW;
      OP_BEQ:  begin kind = K_BEQ; alu_op = ALU_SUB; end
      OP_J:    kind = K_J;
      OP_JAL:  kind = K_JAL;
      default: kind = K_ILL;
    endcase

    case (kind)
      K_R:                     legal = reg_ok(rs_f, NREGS) && reg_ok(rt_f, NREGS) &&
                                       reg_ok(rd_f, NREGS);
      K_ADDI, K_LW, K_SW, K_BEQ: legal = reg_ok(rs_f, NREGS) && reg_ok(rt_f, NREGS);
      K_JAL:                   legal = reg_ok(5'd31, NREGS);
      K_J:                     legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
  end

  // Register file
  logic [31:0]   rd1, rd2;
  logic          rf_we;
  logic [4:0]    rf_wa_full;
  logic [31:0]   rf_wd;
  logic [AW-1:0] ra1, ra2, rf_wa;

  assign ra1   = rs_f[AW-1:0];
  assign ra2   = rt_f[AW-1:0];
  assign rf_wa = rf_wa_full[AW-1:0];

  mc_regfile #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .ra1 (ra1),
    .rd1 (rd1),
    .ra2 (ra2),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // ALU and PC arithmetic
  logic [31:0] op_b, alu_res, exec_res, pc_plus4, branch_tgt, jump_tgt;

  assign op_b       = ((kind == K_R) || (kind == K_BEQ)) ? b_q : imm_sext;
  assign alu_res    = alu_calc(alu_op, a_q, op_b);
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + (imm_sext << 2);
  assign jump_tgt   = {pc_plus4[31:28], tgt, 2'b00};
  // Jumps carry the link value through the ALU register so WB can write it.
  assign exec_res   = ((kind == K_J) || (kind == K_JAL)) ? pc_plus4 : alu_res;

  // Datapath holding registers: IR, operands, ALU result, load data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q  <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      alu_q <= 32'd0;
      mdr_q <= 32'd0;
    end else begin
      if ((state_q == FETCH) && imem_ack) ir_q <= imem_rdata;
      if (state_q == DECODE) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state_q == EXEC) alu_q <= exec_res;
      if ((state_q == MEM) && dmem_ack) mdr_q <= dmem_rdata;
    end
  end

  // Next-state, PC update, timeout counting, register writeback and retire.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = '0;
    cause_d    = cause_q;
    done_d     = 1'b0;
    rf_we      = 1'b0;
    rf_wa_full = rt_f;
    rf_wd      = alu_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = TRAP;
          cause_d = TC_IMEM_TO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        if (!legal) begin
          state_d = TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (kind)
          K_BEQ: begin
            pc_d    = (a_q == b_q) ? branch_tgt : pc_plus4;
            done_d  = 1'b1;
            state_d = FETCH;
          end
          K_J: begin
            pc_d    = jump_tgt;
            done_d  = 1'b1;
            state_d = FETCH;
          end
          K_LW, K_SW: begin
            if (alu_res[1:0] != 2'b00) begin
              state_d = TRAP;
              cause_d = TC_MISALIGN;
            end else begin
              state_d = MEM;
            end
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (kind == K_SW) begin
            pc_d    = pc_plus4;
            done_d  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = TRAP;
          cause_d = TC_DMEM_TO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        rf_we = 1'b1;
        case (kind)
          K_R:     begin rf_wa_full = rd_f;  rf_wd = alu_q; end
          K_LW:    begin rf_wa_full = rt_f;  rf_wd = mdr_q; end
          K_JAL:   begin rf_wa_full = 5'd31; rf_wd = alu_q; end
          default: begin rf_wa_full = rt_f;  rf_wd = alu_q; end
        endcase
        pc_d    = (kind == K_JAL) ? jump_tgt : pc_plus4;
        done_d  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
        cause_d = TC_ILLEGAL;
      end
    endcase
  end

  // FSM state, PC, timeout counter, trap cause and retire pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      cause_q <= TC_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr    = pc_q;
  assign dmem_we      = (state_q == MEM) && (kind == K_SW);
  assign dmem_addr    = (state_q == MEM) ? alu_q : 32'd0;
  assign dmem_wdata   = (state_q == MEM) ? b_q : 32'd0;
  assign pc           = pc_q;
  assign resultadoALU = alu_q;
  assign instr_done   = done_q;
  assign trap         = (state_q == TRAP);
  assign trap_cause   = cause_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: 0-wait instruction memory, configurable
// wait-state data memory, store scoreboard, trap and reset scenarios.
module tb_mc_datapath;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc, resultadoALU;
  logic        instr_done, trap;
  logic [2:0]  trap_cause;

  mc_datapath #(
    .NREGS       (32),
    .RESET_PC    (32'h0),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .pc           (pc),
    .resultadoALU (resultadoALU),
    .instr_done   (instr_done),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  // ---------------- memory models ----------------
  logic [31:0] imem_mem [128];
  logic [31:0] dmem_mem [64];
  logic        imem_hold = 1'b0;
  logic        dmem_hold = 1'b0;
  int          dmem_wait = 0;
  int          dcnt = 0;

  assign imem_ack   = imem_req && !imem_hold;
  assign imem_rdata = imem_mem[imem_addr[8:2]];
  assign dmem_ack   = dmem_req && !dmem_hold && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem_mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int excl_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Completed stores are compared in order against the expected store list.
  always @(negedge clk) begin
    if (imem_req && dmem_req) excl_bad++;
    if (dmem_req && dmem_ack && dmem_we) begin
      dmem_mem[dmem_addr[7:2]] = dmem_wdata;
      if (exp_q.size() == 0) check_val("store_extra", {dmem_addr, dmem_wdata}, 64'd0);
      else                   check_val("store", {dmem_addr, dmem_wdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_res", resultadoALU, 32'h0);
    check_val("rst_done", instr_done, 0);
    check_val("rst_trap", {trap, trap_cause}, 0);
    check_val("rst_dreq", dmem_req, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!instr_done && cyc < budget);
    if (!instr_done) check_val("done_timeout", 0, 1);
  endtask

  task automatic wait_trap(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!trap && cyc < budget);
    if (!trap) check_val("trap_timeout", 0, 1);
  endtask

  task automatic step(input string tag, input int exp_cyc, input logic [31:0] exp_pc,
                      input logic [31:0] exp_res);
    int c;
    wait_done(30, c);
    check_val({tag, "_cyc"}, c, exp_cyc);
    check_val({tag, "_pc"}, pc, exp_pc);
    check_val({tag, "_res"}, resultadoALU, exp_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    reset = 1'b0;
    foreach (imem_mem[i]) imem_mem[i] = 32'h0;
    foreach (dmem_mem[i]) dmem_mem[i] = 32'h0;

    imem_mem[0]  = 32'h20010005; // 0x00 addi r1,r0,5
    imem_mem[1]  = 32'h20020007; // 0x04 addi r2,r0,7
    imem_mem[2]  = 32'h00221820; // 0x08 add  r3,r1,r2
    imem_mem[3]  = 32'hAC030008; // 0x0C sw   r3,8(r0)
    imem_mem[4]  = 32'h8C040008; // 0x10 lw   r4,8(r0)
    imem_mem[5]  = 32'hAC04000C; // 0x14 sw   r4,12(r0)
    imem_mem[6]  = 32'h08000008; // 0x18 j    0x20
    imem_mem[8]  = 32'h0C000040; // 0x20 jal  0x100
    imem_mem[64] = 32'hAC1F0010; // 0x100 sw  r31,16(r0)
    imem_mem[65] = 32'h00222822; // 0x104 sub r5,r1,r2
    imem_mem[66] = 32'h00A1302A; // 0x108 slt r6,r5,r1
    imem_mem[67] = 32'h00223824; // 0x10C and r7,r1,r2
    imem_mem[68] = 32'h00224025; // 0x110 or  r8,r1,r2
    imem_mem[69] = 32'h20000009; // 0x114 addi r0,r0,9
    imem_mem[70] = 32'hAC000014; // 0x118 sw  r0,20(r0)
    imem_mem[71] = 32'h10220005; // 0x11C beq r1,r2,+5 (not taken)
    imem_mem[72] = 32'h1021FFFF; // 0x120 beq r1,r1,-1 (self loop)

    exp_q.push_back({32'd8,  32'd12});
    exp_q.push_back({32'd12, 32'd12});
    exp_q.push_back({32'd16, 32'h24});
    exp_q.push_back({32'd20, 32'd0});

    do_reset();
    check_val("rst_ireq", imem_req, 1);

    step("addi1", 4, 32'h04, 32'd5);
    step("addi2", 4, 32'h08, 32'd7);
    step("add",   4, 32'h0C, 32'd12);
    dmem_wait = 3;
    step("sw8",   7, 32'h10, 32'd8);
    step("lw8",   8, 32'h14, 32'd8);
    step("sw12",  7, 32'h18, 32'd12);
    dmem_wait = 0;
    step("j",     3, 32'h20, 32'h1C);
    step("jal",   4, 32'h100, 32'h24);
    step("sw16",  4, 32'h104, 32'd16);
    step("sub",   4, 32'h108, 32'hFFFFFFFE);
    step("slt",   4, 32'h10C, 32'd1);
    step("and",   4, 32'h110, 32'd5);
    step("or",    4, 32'h114, 32'd7);
    step("addi0", 4, 32'h118, 32'd9);
    step("sw20",  4, 32'h11C, 32'd20);
    step("beq_nt", 3, 32'h120, 32'hFFFFFFFE);
    step("beq_lp1", 3, 32'h120, 32'd0);
    step("beq_lp2", 3, 32'h120, 32'd0);

    // Illegal opcode 0x3F
    imem_mem[0] = 32'hFC000000;
    do_reset();
    wait_trap(20, c);
    check_val("ill_cyc", c, 2);
    check_val("ill_cause", trap_cause, 3'd1);
    repeat (5) @(posedge clk);
    #1;
    check_val("ill_pc", pc, 32'h0);
    check_val("ill_sticky", {trap, imem_req, dmem_req, instr_done}, 4'b1000);

    // Misaligned load
    imem_mem[0] = 32'h8C090002; // lw r9,2(r0)
    do_reset();
    wait_trap(20, c);
    check_val("mis_cyc", c, 3);
    check_val("mis_cause", trap_cause, 3'd4);
    check_val("mis_pc", pc, 32'h0);

    // Instruction fetch timeout
    imem_hold = 1'b1;
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    check_val("ito_early", {trap, imem_req}, 2'b01);
    @(posedge clk); #1;
    check_val("ito_trap", {trap, imem_req}, 2'b10);
    check_val("ito_cause", trap_cause, 3'd2);
    imem_hold = 1'b0;

    // Reset while a store waits in MEM
    imem_mem[0] = 32'hAC000000; // sw r0,0(r0)
    dmem_hold = 1'b1;
    do_reset();
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!dmem_req && c < 20);
    check_val("mem_entry_cyc", c, 3);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rmid_dreq", dmem_req, 0);
    check_val("rmid_pc", pc, 32'h0);
    check_val("rmid_ireq", imem_req, 1);
    @(negedge clk);
    reset = 1'b1;

    // Data access timeout
    wait_trap(40, c);
    check_val("dto_cyc", c, 19);
    check_val("dto_cause", trap_cause, 3'd3);
    check_val("dto_pc", pc, 32'h0);
    dmem_hold = 1'b0;

    @(negedge clk);
    check_val("store_left", exp_q.size(), 0);
    check_val("req_excl", excl_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
